// File: rtl/debounced_updown_counter_if.sv
// rtl/debounced_updown_counter_if.sv - push-button inputs and counter outputs of the debounced counter
interface debounced_updown_counter_if #(
  parameter int WIDTH = 8
);
  logic             key_up_in;
  logic             key_down_in;
  logic             key_clr_in;
  logic [WIDTH-1:0] count;
  logic             up_pressed;
  logic             down_pressed;
  logic             at_max;
  logic             at_min;

  modport master (
    output key_up_in, key_down_in, key_clr_in,
    input  count, up_pressed, down_pressed, at_max, at_min
  );

  modport slave (
    input  key_up_in, key_down_in, key_clr_in,
    output count, up_pressed, down_pressed, at_max, at_min
  );
endinterface

// File: rtl/debounced_updown_counter.sv
// rtl/debounced_updown_counter.sv - three debounced push-buttons driving a wrapping or saturating up/down counter
module debounced_updown_counter #(
  parameter int WIDTH         = 8,
  parameter int DEBOUNCE_TIME = 1000,
  parameter int SATURATE      = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  debounced_updown_counter_if.slave bus
);
  localparam int               RUN_W    = $clog2(DEBOUNCE_TIME + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE_TIME - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;

  // Key index: 0 = up, 1 = down, 2 = clear
  logic [2:0]            raw;
  logic [2:0]            sync1_q, sync2_q;
  logic [2:0]            db_q, db_d;
  logic [2:0]            pulse_q, pulse_d;
  logic [2:0][RUN_W-1:0] run_q, run_d;
  logic [WIDTH-1:0]      count_q, count_d;

  assign raw = {bus.key_clr_in, bus.key_down_in, bus.key_up_in};

  always_comb begin
    db_d    = db_q;
    pulse_d = '0;
    run_d   = '0;
    for (int k = 0; k < 3; k++) begin
      if (sync2_q[k] != db_q[k]) begin
        // The DEBOUNCE_TIME-th consecutive differing sample accepts the new level.
        if (run_q[k] == RUN_LAST) begin
          db_d[k]    = sync2_q[k];
          pulse_d[k] = sync2_q[k];
        end else begin
          run_d[k] = run_q[k] + RUN_W'(1);
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (pulse_q[2]) begin
      count_d = '0;
    end else if (pulse_q[0] && pulse_q[1]) begin
      count_d = count_q;
    end else if (pulse_q[0]) begin
      if (count_q == CNT_MAX) count_d = (SATURATE != 0) ? CNT_MAX : '0;
      else                    count_d = count_q + WIDTH'(1);
    end else if (pulse_q[1]) begin
      if (count_q == '0) count_d = (SATURATE != 0) ? '0 : CNT_MAX;
      else               count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      run_q   <= '0;
      pulse_q <= '0;
      count_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      run_q   <= run_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
    end
  end

  assign bus.count        = count_q;
  assign bus.up_pressed   = pulse_q[0];
  assign bus.down_pressed = pulse_q[1];
  assign bus.at_max       = (count_q == CNT_MAX);
  assign bus.at_min       = (count_q == '0);
endmodule
